// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one serial transmitter among NUM_REQ requesters,
// with optional per-requester frame locking and a completion watchdog.
module uart_tx_arb #(
    parameter int NUM_REQ = 3,
    parameter int TO_W    = 16,
    parameter int TO_CYC  = 32768
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_lock,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   done,
    output logic                 busy,
    output logic                 err_to,
    output logic                 trmt,
    output logic [7:0]           tx_data,
    input  logic                 tx_done
);

    localparam int              PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_gnt;
    logic [TO_W-1:0]    r_wdog;
    logic               r_first;
    logic               r_trmt;
    logic [7:0]         r_tx_data;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] r_done;
    logic               r_err_to;

    logic [PTR_W-1:0]   w_winner;
    logic               w_any;
    logic [PTR_W-1:0]   w_gnt_next;
    logic [7:0]         w_bytes [NUM_REQ];

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] g);
        return NUM_REQ'(1) << g;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_bytes[i] = req_data[8*i +: 8];
        end
    end

    // Scan downward from the farthest slot so the slot nearest rr_ptr is assigned last and wins.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path infers a latch.
        w_winner = '0;
        w_any    = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx]) begin
                w_winner = PTR_W'(idx);
                w_any    = 1'b1;
            end
        end
    end

    assign w_gnt_next = (r_gnt == PTR_W'(NUM_REQ - 1)) ? '0 : r_gnt + PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rr_ptr  <= '0;
            r_gnt     <= '0;
            r_wdog    <= '0;
            r_first   <= 1'b0;
            r_trmt    <= 1'b0;
            r_tx_data <= 8'h00;
            r_ack     <= '0;
            r_done    <= '0;
            r_err_to  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads pre-edge state.
            r_trmt <= 1'b0;
            r_ack  <= '0;
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt     <= w_winner;
                        r_tx_data <= w_bytes[w_winner];
                        r_trmt    <= 1'b1;
                        r_ack     <= onehot(w_winner);
                        r_state   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_wdog  <= '0;
                    r_first <= 1'b1;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // A tx_done level left over from the previous frame is ignored for one cycle.
                    r_first <= 1'b0;
                    r_wdog  <= r_wdog + TO_W'(1);
                    if (tx_done && !r_first) begin
                        r_done <= onehot(r_gnt);
                        if (req_lock[r_gnt] && req[r_gnt]) begin
                            r_tx_data <= w_bytes[r_gnt];
                            r_trmt    <= 1'b1;
                            r_ack     <= onehot(r_gnt);
                            r_state   <= LAUNCH;
                        end else begin
                            r_rr_ptr <= w_gnt_next;
                            r_state  <= IDLE;
                        end
                    end else if (r_wdog == TO_LAST) begin
                        r_err_to <= 1'b1;
                        r_rr_ptr <= w_gnt_next;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign trmt    = r_trmt;
    assign tx_data = r_tx_data;
    assign ack     = r_ack;
    assign done    = r_done;
    assign err_to  = r_err_to;
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: launch-table vectors plus directed
// sequences for timeout, stale tx_done guard and mid-frame reset.
module tb_uart_tx_arb;

    localparam int N      = 3;
    localparam int TO_W   = 8;
    localparam int TO_CYC = 40;
    localparam int FRAME  = 12;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] req_lock = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0] ack;
    logic [N-1:0] done;
    logic         busy;
    logic         err_to;
    logic         trmt;
    logic [7:0]   tx_data;
    logic         tx_done;

    int checks = 0;
    int errors = 0;
    int n_trmt = 0;
    int tx_cnt;
    logic stale_mode = 1'b0;
    logic stuck_low  = 1'b0;

    uart_tx_arb #(.NUM_REQ(N), .TO_W(TO_W), .TO_CYC(TO_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_lock(req_lock),
        .ack(ack), .done(done), .busy(busy), .err_to(err_to),
        .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    // Transmitter model: tx_done drops after trmt and rises FRAME clocks later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt  <= 0;
            tx_done <= 1'b1;
        end else if (trmt) begin
            tx_cnt  <= FRAME;
            tx_done <= stale_mode;
        end else if (tx_cnt > 1) begin
            tx_cnt  <= tx_cnt - 1;
            tx_done <= 1'b0;
        end else if (tx_cnt == 1) begin
            tx_cnt  <= 0;
            tx_done <= !stuck_low;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (trmt) n_trmt++;
            checks++;
            if (!$onehot0(ack) || !$onehot0(done)) begin
                errors++;
                $display("FAIL onehot: ack=%b done=%b required one-hot or zero", ack, done);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_trmt(input int limit, output int n, output logic pb);
        pb = busy;
        step();
        n = 1;
        while (trmt !== 1'b1 && n < limit) begin
            pb = busy;
            step();
            n++;
        end
        check("trmt_seen", {31'd0, trmt}, 32'd1);
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (done == '0 && n < limit);
        check("done_seen", {31'd0, (done != '0)}, 32'd1);
    endtask

    task automatic do_reset();
        req      = '0;
        req_lock = '0;
        req_data = '0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0]   req;
        logic [8*N-1:0] data;
        logic [N-1:0]   lock;
        logic [N-1:0]   exp_ack;
        logic [7:0]     exp_byte;
        logic           relaunch;
    } vec_t;

    vec_t vt [9];

    initial begin
        int   n;
        int   t0;
        logic pb;
        logic seen;

        // Each entry's inputs are applied in the previous entry's LAUNCH cycle,
        // so its lock field is what the DUT samples when the previous byte completes.
        vt[0] = '{3'b111, 24'h322110, 3'b000, 3'b001, 8'h10, 1'b0};
        vt[1] = '{3'b111, 24'h322110, 3'b000, 3'b010, 8'h21, 1'b0};
        vt[2] = '{3'b111, 24'h322110, 3'b000, 3'b100, 8'h32, 1'b0};
        vt[3] = '{3'b111, 24'h322110, 3'b000, 3'b001, 8'h10, 1'b0};
        vt[4] = '{3'b010, 24'h324410, 3'b000, 3'b010, 8'h44, 1'b0};
        vt[5] = '{3'b011, 24'h324401, 3'b000, 3'b001, 8'h01, 1'b0};
        vt[6] = '{3'b011, 24'h324402, 3'b001, 3'b001, 8'h02, 1'b1};
        vt[7] = '{3'b011, 24'h324403, 3'b001, 3'b001, 8'h03, 1'b1};
        vt[8] = '{3'b010, 24'h325503, 3'b000, 3'b010, 8'h55, 1'b0};

        rst_n = 1'b0;
        #2;
        check("rst_trmt", {31'd0, trmt}, 32'd0);
        check("rst_ack", {29'd0, ack}, 32'd0);
        check("rst_done", {29'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err_to", {31'd0, err_to}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        do_reset();

        // Single byte from requester 1.
        req      = 3'b010;
        req_data = 24'h00A500;
        step();
        check("single_trmt", {31'd0, trmt}, 32'd1);
        check("single_ack", {29'd0, ack}, 32'b010);
        check("single_tx_data", {24'd0, tx_data}, 32'hA5);
        check("single_busy", {31'd0, busy}, 32'd1);
        req = '0;
        wait_done(100, n);
        check("single_done", {29'd0, done}, 32'b010);
        check("single_latency", n, FRAME + 2);
        step();
        check("single_idle_busy", {31'd0, busy}, 32'd0);
        check("single_done_pulse", {29'd0, done}, 32'd0);

        // Contention and locked frame from the launch table.
        do_reset();
        t0 = n_trmt;
        for (int i = 0; i < 9; i++) begin
            req      = vt[i].req;
            req_data = vt[i].data;
            req_lock = vt[i].lock;
            wait_trmt(100, n, pb);
            check($sformatf("vec%0d_ack", i), {29'd0, ack}, {29'd0, vt[i].exp_ack});
            check($sformatf("vec%0d_byte", i), {24'd0, tx_data}, {24'd0, vt[i].exp_byte});
            check($sformatf("vec%0d_done", i), {29'd0, done},
                  vt[i].relaunch ? {29'd0, vt[i].exp_ack} : 32'd0);
            check($sformatf("vec%0d_prev_busy", i), {31'd0, pb}, {31'd0, vt[i].relaunch});
        end
        req      = '0;
        req_lock = '0;
        wait_done(100, n);
        check("table_last_done", {29'd0, done}, 32'b010);
        step();
        check("table_idle", {31'd0, busy}, 32'd0);
        check("table_trmt_count", n_trmt - t0, 9);

        // Watchdog: transmitter never completes.
        stuck_low = 1'b1;
        req       = 3'b100;
        req_data  = 24'h770000;
        wait_trmt(100, n, pb);
        check("to_ack", {29'd0, ack}, 32'b100);
        req  = '0;
        seen = 1'b0;
        for (int i = 0; i < TO_CYC; i++) begin
            step();
            if (done != '0) seen = 1'b1;
        end
        check("to_not_yet", {31'd0, err_to}, 32'd0);
        check("to_still_busy", {31'd0, busy}, 32'd1);
        step();
        if (done != '0) seen = 1'b1;
        check("to_err", {31'd0, err_to}, 32'd1);
        check("to_idle", {31'd0, busy}, 32'd0);
        check("to_no_done", {31'd0, seen}, 32'd0);
        stuck_low = 1'b0;
        req       = 3'b001;
        req_data  = 24'h00005A;
        wait_trmt(100, n, pb);
        check("after_to_ack", {29'd0, ack}, 32'b001);
        check("after_to_byte", {24'd0, tx_data}, 32'h5A);
        req = '0;
        wait_done(100, n);
        check("after_to_done", {29'd0, done}, 32'b001);
        check("after_to_latency", n, FRAME + 2);
        check("err_sticky", {31'd0, err_to}, 32'd1);
        step();

        // Stale tx_done level held high through launch.
        stale_mode = 1'b1;
        req        = 3'b010;
        req_data   = 24'h003C00;
        wait_trmt(100, n, pb);
        check("guard_ack", {29'd0, ack}, 32'b010);
        req = '0;
        step();
        check("guard_w1", {29'd0, done}, 32'd0);
        step();
        check("guard_w2", {29'd0, done}, 32'd0);
        stale_mode = 1'b0;
        wait_done(100, n);
        check("guard_done", {29'd0, done}, 32'b010);
        check("guard_latency", n, FRAME);
        step();

        // Reset in the middle of a frame.
        req      = 3'b100;
        req_data = 24'h990000;
        wait_trmt(100, n, pb);
        check("mid_ack", {29'd0, ack}, 32'b100);
        req = '0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_trmt", {31'd0, trmt}, 32'd0);
        check("mid_rst_ack", {29'd0, ack}, 32'd0);
        check("mid_rst_done", {29'd0, done}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_err", {31'd0, err_to}, 32'd0);
        check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        req      = 3'b100;
        req_data = 24'hC30000;
        wait_trmt(100, n, pb);
        check("post_rst_latency", n, 1);
        check("post_rst_ack", {29'd0, ack}, 32'b100);
        check("post_rst_byte", {24'd0, tx_data}, 32'hC3);
        req = '0;
        wait_done(100, n);
        check("post_rst_done", {29'd0, done}, 32'b100);
        step();
        check("post_rst_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
Round-robin arbiter and sequencer that shares one serial transmitter among NUM_REQ requesters (command response, telemetry, debug). It picks a requester and drives the transmitter's trmt/tx_data launch interface. It then waits for the transmitter's tx_done level and returns per-requester ack/done pulses. A lock input lets a requester send multi-byte frames back-to-back without being interleaved with other requesters. A watchdog flags a transmitter that never reports completion.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
TO_W, 16, width of the watchdog counter
TO_CYC, 32768, clocks in WAIT without tx_done before timeout (must exceed one 10-bit frame, about 26050 clocks)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester byte request, level; held until ack
req_data  in  8*NUM_REQ  byte for requester i at [8i+7:8i]; stable while req[i] is high and ack not yet seen
req_lock  in  NUM_REQ  requester i wants to keep the grant after the current byte
ack  out  NUM_REQ  one-cycle pulse: byte for requester i launched; requester may change data or drop req next cycle
done  out  NUM_REQ  one-cycle pulse: byte for requester i fully shifted out
busy  out  1  high in every state except IDLE
err_to  out  1  sticky watchdog flag; cleared only by reset
trmt  out  1  registered one-cycle launch pulse to the transmitter
tx_data  out  8  registered byte to the transmitter; valid in the trmt cycle and held until the next launch
tx_done  in  1  transmitter completion level; drops the cycle after trmt and rises when the frame ends

Behaviour:
- Reset: state IDLE, rr_ptr=0, gnt=0, trmt=0, tx_data=8'h00, ack=0, done=0, busy=0, err_to=0, watchdog=0.
- States: IDLE, LAUNCH, WAIT.
- IDLE: if any req bit is high, choose the winner g by round-robin.
  - Search starts at rr_ptr and proceeds rr_ptr+1 ... wrapping modulo NUM_REQ.
  - On that edge: gnt<=g, tx_data<=req_data[g], trmt<=1, ack[g]<=1, state<=LAUNCH.
  - If no req bit is high, stay in IDLE.
- LAUNCH, exactly one cycle: trmt=1 and ack[g]=1 are visible. On the edge: trmt<=0, ack<=0, watchdog<=0, first<=1, state<=WAIT.
- WAIT:
  - tx_done is ignored in the first WAIT cycle (first=1) as a guard against a stale level.
  - The watchdog increments every WAIT cycle.
  - When tx_done=1 with first=0:
    - done[g]<=1 for one cycle.
    - If req_lock[g] && req[g] in that cycle: relaunch the same g directly. tx_data<=req_data[g], trmt<=1, ack[g]<=1, state<=LAUNCH, rr_ptr unchanged.
    - Otherwise: rr_ptr<=(g+1) mod NUM_REQ, state<=IDLE.
  - If watchdog reaches TO_CYC-1 with no tx_done: err_to<=1, rr_ptr<=(g+1) mod NUM_REQ, state<=IDLE. No done pulse is issued.
- Latency:
  - From req high in IDLE to trmt visible: 1 clock.
  - Requester-to-requester gap: done cycle, then 1 IDLE cycle, then LAUNCH.
  - Locked back-to-back gap: done and the relaunch on the same edge, so ack and done are visible together in the LAUNCH cycle.
- Simultaneous events:
  - req changes during LAUNCH or WAIT are ignored until the next arbitration.
  - req_lock is sampled only at the tx_done cycle.
  - Dropping req[g] while locked ends the lock.
  - If req[g] is low at arbitration, it is not granted; there is no stale grant.
- ack and done are one-hot or zero. At most one bit of each is high in any cycle.
- Reset asserted mid-operation returns immediately to reset values. The transmitter is reset by the same rst_n.

Test Plan:
- Single byte: req=3'b010, data1=8'hA5 -> 1 clock later trmt=1, ack=3'b010, tx_data=8'hA5. done=3'b010 one clock after tx_done rises. busy low again the following cycle.
- Contention: req=3'b111 held with no locks -> grant order 0,1,2,0. One trmt per frame. Bytes appear on the serial line in that order.
- Locked frame: req0 with lock, bytes 8'h01,8'h02,8'h03 (lock dropped with the third byte) while req1 is high -> three consecutive requester-0 frames, then requester 1. Each relaunch trmt coincides with done.
- Timeout: tx_done tied low after launch -> err_to=1 after TO_CYC WAIT cycles, state IDLE, no done pulse. The next request is still served.
- Reset mid-frame: rst_n low during WAIT -> all outputs return to reset values in the same cycle. After release, req=3'b100 is granted normally.
- Guard: tx_done held high through launch (stale level) -> done is not issued in the first WAIT cycle.
